// File: rtl/interp_pkg.sv
// Shared definitions for the interpolator tap scheduler: geometry of the
// polyphase filter, the queued request record and the controller states.
package interp_pkg;

    // Polyphase geometry (branches x taps per branch).
    localparam int OSF      = 20;
    localparam int TAPS_PPH = 5;

    // Delay-line depth and the address widths derived from it.
    localparam int DEPTH = OSF * TAPS_PPH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(OSF * TAPS_PPH);

    // Width of the incoming phase index and of the tap counter.
    localparam int PW = 5;
    localparam int KW = (TAPS_PPH > 1) ? $clog2(TAPS_PPH) : 1;

    // One pending symbol: the branch to use and where the newest sample sat.
    typedef struct packed {
        logic [PW-1:0] phase;
        logic [AW-1:0] snap;
    } req_t;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/interp_req_fifo.sv
// Two-entry first-word-fall-through request queue. A push into a full queue
// is accepted only when a pop frees a slot in the same cycle; otherwise it is
// ignored and the stored entries are left untouched.
module interp_req_fifo
    import interp_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);

    localparam int ENTRIES = 2;

    req_t       mem_reg [ENTRIES];
    logic       wr_idx_reg;
    logic       rd_idx_reg;
    logic [1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign empty    = (count_reg == 2'd0);
    assign full     = (count_reg == 2'd2);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_reg[rd_idx_reg];

    // Storage slots: each slot captures the pushed record when it is the write target.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_idx_reg == 1'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_reg <= 1'b0;
            rd_idx_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_idx_reg <= ~wr_idx_reg;
            end
            if (do_pop) begin
                rd_idx_reg <= ~rd_idx_reg;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// Polyphase interpolator tap scheduler. Tracks the delay-line write pointer,
// queues symbol requests and walks the taps of one branch per symbol, driving
// delay-line / coefficient addresses and MAC control strobes.
// Optional feature: define INTERP_SCHED_STATS_EN to add the saturating
// drop counter output drop_cnt_o.
// Address widths come from interp_pkg; parameter overrides must keep
// OSF*TAPS_PPH equal to interp_pkg::DEPTH.
module interp_sched
    import interp_pkg::*;
#(
    parameter int OSF      = interp_pkg::OSF,
    parameter int TAPS_PPH = interp_pkg::TAPS_PPH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          iq_raw_val_i,
    input  logic          sym_valid_i,
    input  logic [PW-1:0] phase_int_i,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [CW-1:0] coef_addr_o,
    output logic          mac_clr_o,
    output logic          mac_en_o,
    output logic          mac_last_o,
    output logic          busy_o,
    output logic          drop_o
`ifdef INTERP_SCHED_STATS_EN
    ,
    output logic [15:0]   drop_cnt_o
`endif
);

    state_t        state_reg;
    state_t        state_next;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] k_next;
    req_t          cur_reg;
    req_t          cur_next;
    logic [AW-1:0] wr_ptr_reg;

    logic [PW-1:0] phase_sat;
    req_t          incoming;
    req_t          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass;
    logic          launch;
    logic          run;

    // Out-of-range branch indices clamp to the last branch.
    assign phase_sat = (int'(phase_int_i) >= OSF) ? PW'(OSF - 1) : phase_int_i;
    assign incoming  = '{phase: phase_sat, snap: wr_ptr_reg};

    // A request consumed directly by an idle/finishing controller never enters the queue.
    assign fifo_push = sym_valid_i & ~bypass;
    assign drop_o    = fifo_push & fifo_full & ~fifo_pop;

    assign run      = (state_reg == ST_RUN);
    assign busy_o   = run | ~fifo_empty;
    assign wr_ptr_o = wr_ptr_reg;

    interp_req_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (incoming),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Delay-line write pointer, wrapping at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
        end else if (iq_raw_val_i) begin
            wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
        end
    end

    // Controller state, tap counter and active request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            cur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            cur_reg   <= cur_next;
        end
    end

    // Next-state and MAC strobes; a new symbol starts from the queue head, or
    // straight from the strobe when the queue is empty, so there is no bubble.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        cur_next   = cur_reg;
        fifo_pop   = 1'b0;
        bypass     = 1'b0;
        launch     = 1'b0;
        mac_en_o   = 1'b0;
        mac_clr_o  = 1'b0;
        mac_last_o = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                launch = 1'b1;
            end
            ST_RUN: begin
                mac_en_o  = 1'b1;
                mac_clr_o = (k_reg == '0);
                if (k_reg == KW'(TAPS_PPH - 1)) begin
                    mac_last_o = 1'b1;
                    launch     = 1'b1;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                k_next     = '0;
            end
        endcase
        if (launch) begin
            k_next = '0;
            if (!fifo_empty) begin
                state_next = ST_RUN;
                cur_next   = fifo_head;
                fifo_pop   = 1'b1;
            end else if (sym_valid_i) begin
                state_next = ST_RUN;
                cur_next   = incoming;
                bypass     = 1'b1;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // Tap addresses: walk back through the delay line one branch stride per tap.
    always_comb begin : addr_calc
        int off;
        int diff;
        off         = int'(cur_reg.phase) + int'(k_reg) * OSF;
        diff        = int'(cur_reg.snap) - off;
        if (diff < 0) begin
            diff = diff + DEPTH;
        end
        rd_addr_o   = '0;
        coef_addr_o = '0;
        if (run) begin
            rd_addr_o   = AW'(diff);
            coef_addr_o = CW'(int'(cur_reg.phase) * TAPS_PPH + int'(k_reg));
        end
    end

`ifdef INTERP_SCHED_STATS_EN
    logic [15:0] drop_cnt_reg;

    // Saturating count of discarded requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_reg <= '0;
        end else if (drop_o && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_interp_sched.sv
// Directed self-checking bench for interp_sched. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_interp_sched;

    logic       clk;
    logic       reset_n;
    logic       iq_raw_val_i;
    logic       sym_valid_i;
    logic [4:0] phase_int_i;
    logic [6:0] wr_ptr_o;
    logic [6:0] rd_addr_o;
    logic [6:0] coef_addr_o;
    logic       mac_clr_o;
    logic       mac_en_o;
    logic       mac_last_o;
    logic       busy_o;
    logic       drop_o;
`ifdef INTERP_SCHED_STATS_EN
    logic [15:0] drop_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    interp_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iq_raw_val_i (iq_raw_val_i),
        .sym_valid_i  (sym_valid_i),
        .phase_int_i  (phase_int_i),
        .wr_ptr_o     (wr_ptr_o),
        .rd_addr_o    (rd_addr_o),
        .coef_addr_o  (coef_addr_o),
        .mac_clr_o    (mac_clr_o),
        .mac_en_o     (mac_en_o),
        .mac_last_o   (mac_last_o),
        .busy_o       (busy_o),
        .drop_o       (drop_o)
`ifdef INTERP_SCHED_STATS_EN
        ,
        .drop_cnt_o   (drop_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ptr"}, 32'(wr_ptr_o), 0);
        check({tag, "_rd"},     32'(rd_addr_o), 0);
        check({tag, "_coef"},   32'(coef_addr_o), 0);
        check({tag, "_en"},     32'(mac_en_o), 0);
        check({tag, "_clr"},    32'(mac_clr_o), 0);
        check({tag, "_last"},   32'(mac_last_o), 0);
        check({tag, "_busy"},   32'(busy_o), 0);
        check({tag, "_drop"},   32'(drop_o), 0);
    endtask

    // Hold reset with live stimulus (which must be ignored), then release.
    task automatic do_reset(input string tag);
        reset_n      = 1'b0;
        iq_raw_val_i = 1'b1;
        sym_valid_i  = 1'b1;
        phase_int_i  = 5'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero(tag);
`ifdef INTERP_SCHED_STATS_EN
        check({tag, "_dropcnt"}, 32'(drop_cnt_o), 0);
`endif
        iq_raw_val_i = 1'b0;
        sym_valid_i  = 1'b0;
        phase_int_i  = 5'd0;
        reset_n      = 1'b1;
        @(posedge clk);
        #1;
        $display("reset %s released", tag);
    endtask

    task automatic raw_valids(input int n);
        iq_raw_val_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        iq_raw_val_i = 1'b0;
    endtask

    // One symbol from idle: strobe in cycle t, taps in cycles t+1..t+5.
    task automatic run_sym(input string tag, input logic [4:0] ph, input logic raw_too,
                           input int r0, input int r1, input int r2, input int r3,
                           input int r4, input int c0);
        int rd_exp [5];
        rd_exp[0] = r0; rd_exp[1] = r1; rd_exp[2] = r2; rd_exp[3] = r3; rd_exp[4] = r4;
        iq_raw_val_i = raw_too;
        sym_valid_i  = 1'b1;
        phase_int_i  = ph;
        @(negedge clk);
        check({tag, "_en_t0"}, 32'(mac_en_o), 0);
        check({tag, "_drop_t0"}, 32'(drop_o), 0);
        @(posedge clk);
        #1;
        iq_raw_val_i = 1'b0;
        sym_valid_i  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("%s_en_k%0d", tag, k),   32'(mac_en_o), 1);
            check($sformatf("%s_rd_k%0d", tag, k),   32'(rd_addr_o), 32'(rd_exp[k]));
            check($sformatf("%s_coef_k%0d", tag, k), 32'(coef_addr_o), 32'(c0 + k));
            check($sformatf("%s_clr_k%0d", tag, k),  32'(mac_clr_o), (k == 0) ? 1 : 0);
            check($sformatf("%s_last_k%0d", tag, k), 32'(mac_last_o), (k == 4) ? 1 : 0);
            check($sformatf("%s_busy_k%0d", tag, k), 32'(busy_o), 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_en_after"}, 32'(mac_en_o), 0);
        check({tag, "_busy_after"}, 32'(busy_o), 0);
        @(posedge clk);
        #1;
        $display("symbol %s phase_in=%0d complete", tag, ph);
    endtask

    // Strobes per mask bit (phases 0,1,2,... in strobe order, wr_ptr held);
    // accepted symbols run contiguously from cycle 1 so coef_addr = cycle-1.
    task automatic run_burst(input string tag, input logic [31:0] mask, input int n_cyc,
                             input int exp_syms, input int exp_drop_at);
        int en_cnt   = 0;
        int last_cnt = 0;
        int drop_cnt = 0;
        int drop_at  = -1;
        int ph       = 0;
        for (int c = 0; c < n_cyc; c++) begin
            sym_valid_i = mask[c];
            phase_int_i = 5'(ph);
            if (mask[c]) ph++;
            @(negedge clk);
            if (mac_en_o) begin
                en_cnt++;
                check($sformatf("%s_coef_c%0d", tag, c), 32'(coef_addr_o), 32'(c - 1));
                if (((c - 1) % 5) == 0) begin
                    check($sformatf("%s_rd_c%0d", tag, c), 32'(rd_addr_o),
                          32'((100 - (c - 1) / 5) % 100));
                end
            end
            if (mac_last_o) begin
                last_cnt++;
                $display("burst %s symbol %0d done at cycle %0d", tag, last_cnt, c);
            end
            if (drop_o) begin
                drop_cnt++;
                drop_at = c;
            end
            @(posedge clk);
            #1;
        end
        sym_valid_i = 1'b0;
        phase_int_i = 5'd0;
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(5 * exp_syms));
        check({tag, "_lasts"}, 32'(last_cnt), 32'(exp_syms));
        check({tag, "_drops"}, 32'(drop_cnt), (exp_drop_at >= 0) ? 1 : 0);
        check({tag, "_drop_cycle"}, 32'(drop_at), 32'(exp_drop_at));
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(busy_o), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_cnt;
        int last_cnt;
        reset_n      = 1'b0;
        iq_raw_val_i = 1'b0;
        sym_valid_i  = 1'b0;
        phase_int_i  = 5'd0;

        do_reset("rst0");

        // Single request: 37 raw samples, phase 3.
        raw_valids(37);
        @(negedge clk);
        check("wr_ptr_37", 32'(wr_ptr_o), 37);
        @(posedge clk);
        #1;
        run_sym("single", 5'd3, 1'b0, 34, 14, 94, 74, 54, 15);

        // Wrap: 99 samples, strobe together with the 100th.
        do_reset("rst1");
        raw_valids(99);
        @(negedge clk);
        check("wr_ptr_99", 32'(wr_ptr_o), 99);
        @(posedge clk);
        #1;
        run_sym("wrap", 5'd0, 1'b1, 99, 79, 59, 39, 19, 0);
        check("wr_ptr_wrapped", 32'(wr_ptr_o), 0);

        // Saturation: phase 25 clamps to 19, snap 0.
        run_sym("sat", 5'd25, 1'b0, 81, 61, 41, 21, 1, 95);

        // Back-to-back, overflow, and push+pop on a full queue.
        run_burst("b2b", 32'b111, 18, 3, -1);
        run_burst("ovf", 32'b1111, 18, 3, 3);
`ifdef INTERP_SCHED_STATS_EN
        check("ovf_dropcnt", 32'(drop_cnt_o), 1);
`endif
        run_burst("fullpp", 32'b100111, 23, 4, -1);

        // Reset in the middle of a symbol at tap k=2.
        raw_valids(5);
        sym_valid_i = 1'b1;
        phase_int_i = 5'd3;
        @(posedge clk);
        #1;
        sym_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_en_k2", 32'(mac_en_o), 1);
        check("mid_coef_k2", 32'(coef_addr_o), 17);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        en_cnt   = 0;
        last_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en_cnt   += int'(mac_en_o);
            last_cnt += int'(mac_last_o);
            check($sformatf("mid_busy_c%0d", c), 32'(busy_o), 0);
        end
        check("mid_en_after", 32'(en_cnt), 0);
        check("mid_last_after", 32'(last_cnt), 0);
        $display("reset mid-symbol scenario complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
